// File: rtl/matrix_alu_seq.sv
// Sequential DIM x DIM matrix ALU on the execution-engine side bus.
// One result element is produced per clock under a start/busy/done handshake, with optional signed saturation.
module matrix_alu_seq #(
  parameter int         DIM  = 4,
  parameter int         DW   = 16,
  parameter logic [3:0] BASE = 4'h2
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic [15:0]           address,
  input  logic                  nRead,
  input  logic                  nWrite,
  input  logic [DIM*DIM*DW-1:0] ExeDataOut,
  output logic [DIM*DIM*DW-1:0] MatrixDataOut,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  localparam int NB = DIM*DIM*DW;
  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int AW = 2*DW + $clog2(DIM) + 2;
  localparam logic [CW-1:0] LAST = CW'(DIM-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_MUL  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_TRN  = 4'd3;
  localparam logic [3:0] OP_SCL  = 4'd4;
  localparam logic [3:0] OP_SIMM = 4'd5;

  localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [1:0]    state;
  logic [CW-1:0] row, col;
  logic [3:0]    op;
  logic          sat;
  logic [DW-1:0] scalar;
  logic [NB-1:0] src1, src2, result;
  logic [DW-1:0] elem;
  logic signed [AW-1:0] acc;

  logic [3:0] fn;
  logic       sel, both_low, wr_strobe, rd_strobe, legal_op;
  logic       req_wr, req_rd, req_start, start_ok, err_set;
  logic       addr_unused;

  assign fn        = address[3:0];
  assign sel       = (address[15:12] == BASE);
  assign both_low  = !nRead && !nWrite;
  assign wr_strobe = !nWrite && nRead;
  assign rd_strobe = !nRead && nWrite;
  assign legal_op  = (address[7:4] <= OP_SIMM);

  assign req_wr    = sel && wr_strobe && (fn == 4'd0 || fn == 4'd1);
  assign req_rd    = sel && rd_strobe && (fn == 4'd2);
  assign req_start = sel && !both_low && (fn == 4'd3);
  assign start_ok  = req_start && !Busy && legal_op;
  assign err_set   = sel && (both_low || ((req_wr || req_rd || req_start) && Busy) || (req_start && !legal_op));

  assign addr_unused = ^address[11:9];

  // Operands are zero-extended in wrap mode and sign-extended in saturate mode, so one datapath serves both.
  function automatic logic signed [AW-1:0] ext(input logic [DW-1:0] v, input logic s);
    return s ? {{(AW-DW){v[DW-1]}}, v} : {{(AW-DW){1'b0}}, v};
  endfunction

  always_comb begin
    int ri;
    int ci;
    logic [DW-1:0] a_el, b_el;
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    ri   = int'(row);
    ci   = int'(col);
    a_el = src1[(ri*DIM + ci)*DW +: DW];
    b_el = src2[(ri*DIM + ci)*DW +: DW];
    acc  = '0;
    elem = '0;
    case (op)
      OP_MUL:
        for (int k = 0; k < DIM; k++)
          acc = acc + ext(src1[(ri*DIM + k)*DW +: DW], sat) * ext(src2[(k*DIM + ci)*DW +: DW], sat);
      OP_ADD:  acc = ext(a_el, sat) + ext(b_el, sat);
      OP_SUB:  acc = ext(a_el, sat) - ext(b_el, sat);
      OP_SCL:  acc = ext(a_el, sat) * ext(src2[DW-1:0], sat);
      OP_SIMM: acc = ext(a_el, sat) * ext(scalar, sat);
      default: acc = '0;
    endcase
    if (op == OP_TRN)   elem = src1[(ci*DIM + ri)*DW +: DW];
    else if (!sat)      elem = acc[DW-1:0];
    else if (acc > SMAX) elem = SMAX[DW-1:0];
    else if (acc < SMIN) elem = SMIN[DW-1:0];
    else                elem = acc[DW-1:0];
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      // NOTE: operand and result arrays are reset too, so an aborted op never leaves a partial result visible.
      state         <= S_IDLE;
      row           <= '0;
      col           <= '0;
      op            <= '0;
      sat           <= 1'b0;
      scalar        <= '0;
      src1          <= '0;
      src2          <= '0;
      result        <= '0;
      MatrixDataOut <= '0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Error         <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_RUN: begin
          result[(int'(row)*DIM + int'(col))*DW +: DW] <= elem;
          if (col == LAST) begin
            col <= '0;
            if (row == LAST) begin
              row   <= '0;
              state <= S_DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else begin
              row <= row + CW'(1);
            end
          end else begin
            col <= col + CW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (req_wr && !Busy) begin
        if (fn[0]) src2 <= ExeDataOut;
        else       src1 <= ExeDataOut;
      end
      if (req_rd && !Busy) MatrixDataOut <= result;

      // NOTE: these non-blocking updates come after the FSM case, so a start in the DONE cycle overrides the return to IDLE.
      if (start_ok) begin
        state <= S_RUN;
        row   <= '0;
        col   <= '0;
        op    <= address[7:4];
        sat   <= address[8];
        Busy  <= 1'b1;
        Error <= 1'b0;
        if (address[7:4] == OP_SIMM) scalar <= ExeDataOut[DW-1:0];
      end else if (err_set) begin
        Error <= 1'b1;
      end
    end
  end

endmodule

// File: doc/matrix_alu_seq.md
# matrix_alu_seq

Parametrised, sequential successor to the 4x4 matrix ALU. Operates on DIM x DIM matrices of DW-bit elements and computes one result element per clock under a start/busy/done handshake. Adds a saturating signed mode and a sticky error flag. Sits on the execution-engine side bus at the same address window as the existing matrix unit: operands come in on ExeDataOut, the result goes out on MatrixDataOut.

## Interface
- DIM, 4: matrix dimension (2..8)
- DW, 16: element width in bits (8..32)
- BASE, 4'h2: value of address[15:12] that selects this block
- Clk  input  1  single clock; all logic on rising edge
- nReset  input  1  synchronous, active-low reset, sampled on rising Clk
- address  input  16  [15:12] block select, [8] saturate mode, [7:4] opcode, [3:0] function
- nRead  input  1  active-low read strobe
- nWrite  input  1  active-low write strobe
- ExeDataOut  input  DIM*DIM*DW  operand bus; element [r][c] at bits (r*DIM+c)*DW +: DW
- MatrixDataOut  output  DIM*DIM*DW  result bus, same packing, registered
- Busy  output  1  high while an operation is running
- Done  output  1  one-cycle pulse when the last element is written
- Error  output  1  sticky protocol/opcode error

## Operation
- The block is selected when address[15:12]==BASE. When it is not selected, nothing changes.
- Function address[3:0] decode:
  - 0 with nWrite=0, nRead=1: src1 <= ExeDataOut
  - 1 with nWrite=0, nRead=1: src2 <= ExeDataOut
  - 2 with nRead=0, nWrite=1: MatrixDataOut <= result
  - 3: start the opcode in address[7:4]. Mode sat <= address[8]. For SCALEIMM, scalar <= ExeDataOut[DW-1:0].
  - Other codes: ignored, no error.
- Opcodes (each produces result[r][c]):
  - 0 MULTIPLY: sum over k of src1[r][k]*src2[k][c]
  - 1 ADD: src1+src2
  - 2 SUBTRACT: src1-src2
  - 3 TRANSPOSE: src1[c][r]
  - 4 SCALE: src1[r][c]*src2[0][0]
  - 5 SCALEIMM: src1[r][c]*scalar
  - 6-15: illegal. Set Error, do not start.
- Arithmetic is computed at full precision: products are 2*DW bits, and the MULTIPLY sum is 2*DW+clog2(DIM) bits.
  - sat=0: operands unsigned, result = low DW bits (wrap).
  - sat=1: operands signed two's complement, result clamped to [-2^(DW-1), 2^(DW-1)-1].
  - TRANSPOSE ignores sat.
- FSM states:
  - IDLE: on a legal start, go to RUN with idx=0.
  - RUN: each cycle write result element idx (row-major, idx = r*DIM+c), then idx++. After idx=DIM*DIM-1 is written, go to DONE.
  - DONE: Done=1 for one cycle, then IDLE.
- Error is set by any of:
  - a write (function 0/1) or start while Busy; the access is ignored and the running op is unaffected
  - a read while Busy; MatrixDataOut is unchanged
  - nRead=0 and nWrite=0 together while selected; no other action
  - an illegal opcode
- Error clears only on reset or on a legal start accepted in IDLE.
- While selected, nRead=1 and nWrite=1 with function 0/1/2 do nothing.
- A start in the DONE cycle is accepted, since Busy is already 0.

## Timing
- Reset (nReset=0 at a rising edge) puts the block in a known state:
  - FSM to IDLE, idx=0, sat=0, scalar=0
  - src1, src2, result, MatrixDataOut all 0
  - Busy=0, Done=0, Error=0
- Reset mid-operation aborts immediately and leaves no partial result.
- Operand writes take effect at the edge where they are sampled and are usable by a start on the next cycle.
- Start sampled at edge T:
  - Busy=1 from T+1.
  - Element idx is written at edge T+1+idx.
  - Busy falls and Done=1 in cycle T+1+DIM*DIM.
  - Total latency is DIM*DIM+1 cycles, i.e. 17 for DIM=4.
- Read: MatrixDataOut updates at the edge sampling the read and holds until the next accepted read or reset.
- Busy and Done are registered and never high at the same time.

## Test plan
- Reset, then write src1 = element value idx+1 (1..16) and src2 = all 0x0001. Start ADD with sat=0, wait for Done, read. Expect elements 2..17, Busy high for exactly 16 cycles, Done at cycle 17.
- Write src1 = identity and src2 = element idx. Start MULTIPLY and read back: result equals src2. Swap in src1 = all 0x0002: each element is 2*(column sum of src2), e.g. result[0][0]=2*(0+4+8+12)=48.
- Write src1 all 0x7FFF and src2 all 0x0002. Start SCALE with sat=1: every element reads 0x7FFF. Repeat with sat=0: every element reads 0xFFFE. Then SUBTRACT 0x8000-0x0001 with sat=1 gives 0x8000.
- Start TRANSPOSE of src1 = element idx: result[1][0]=1 and result[0][1]=4. Then start SCALEIMM with ExeDataOut[15:0]=3: result[2][3]=33.
- Start opcode 7: Error=1, Busy stays 0. Start ADD during Busy: Error stays 1 and the original op completes with the correct values. Next legal start in IDLE clears Error.
- Pull nReset low at cycle 8 of a MULTIPLY: the next cycle shows Busy=0, Done=0, and a subsequent read returns all zero.
